// File: rtl/ac_pkg.sv
// Shared widths, op codes and FSM state type for the Aho-Corasick table loader.
package ac_pkg;

  localparam int unsigned STATE_W = 8;
  localparam int unsigned CHARA_W = 4;
  localparam int unsigned ADDR_W  = STATE_W + CHARA_W;
  localparam logic [STATE_W-1:0] FAIL_MARK = 8'hFF;

  typedef enum logic [1:0] {
    OP_GOTO = 2'b00,
    OP_FAIL = 2'b01,
    OP_RSVD = 2'b10,
    OP_END  = 2'b11
  } op_e;

  typedef enum logic [1:0] {StIdle, StClear, StLoad, StDone} ld_state_e;

  typedef struct packed {
    logic goto_wr;
    logic fail_wr;
    logic is_end;
    logic bad;
  } rec_dec_t;

endpackage

// File: rtl/ac_table_loader_if.sv
// Record stream in, goto/failure RAM write ports out.
interface ac_table_loader_if;
  import ac_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [23:0]        in_data;
  logic               goto_we;
  logic [ADDR_W-1:0]  goto_waddr;
  logic [STATE_W-1:0] goto_wdata;
  logic               fail_we;
  logic [ADDR_W-1:0]  fail_waddr;
  logic [STATE_W-1:0] fail_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, goto_we, goto_waddr, goto_wdata, fail_we, fail_waddr, fail_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, goto_we, goto_waddr, goto_wdata, fail_we, fail_waddr, fail_wdata
  );
endinterface

// File: rtl/ac_table_loader.sv
// Clears the goto/failure tables on start, then turns a record stream into one
// registered RAM write per record until the end record arrives.
module ac_table_loader
  import ac_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  ac_table_loader_if.master   bus,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   goto_cnt_o,
  output logic [8:0]          fail_cnt_o
);

  function automatic rec_dec_t decode(input op_e op, input logic [STATE_W-1:0] st,
                                      input logic [STATE_W-1:0] tgt);
    rec_dec_t d;
    d = '0;
    unique case (op)
      OP_GOTO: d.goto_wr = 1'b1;
      // A failure link must point to a shallower state; only the root may point anywhere.
      OP_FAIL: if (st != '0 && tgt >= st) d.bad = 1'b1; else d.fail_wr = 1'b1;
      OP_RSVD: d.bad = 1'b1;
      OP_END:  d.is_end = 1'b1;
    endcase
    return d;
  endfunction

  ld_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  clr_q, clr_d;
  logic               gwe_q, gwe_d, fwe_q, fwe_d, err_q, err_d;
  logic [ADDR_W-1:0]  gaddr_q, gaddr_d, faddr_q, faddr_d;
  logic [STATE_W-1:0] gdata_q, gdata_d, fdata_q, fdata_d;
  logic [ADDR_W-1:0]  gcnt_q, gcnt_d;
  logic [8:0]         fcnt_q, fcnt_d;

  logic [STATE_W-1:0] rec_st, rec_tgt;
  logic [CHARA_W-1:0] rec_ch;
  rec_dec_t           dec;
  logic               unused_rsvd;

  assign rec_st      = bus.in_data[21:14];
  assign rec_ch      = bus.in_data[13:10];
  assign rec_tgt     = bus.in_data[7:0];
  assign unused_rsvd = ^bus.in_data[9:8];
  assign dec         = decode(op_e'(bus.in_data[23:22]), rec_st, rec_tgt);

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    gwe_d   = 1'b0;
    gaddr_d = gaddr_q;
    gdata_d = gdata_q;
    fwe_d   = 1'b0;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    err_d   = err_q;
    gcnt_d  = gcnt_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StClear;
          clr_d   = '0;
          err_d   = 1'b0;
          gcnt_d  = '0;
          fcnt_d  = '0;
        end
      end
      StClear: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == '1) state_d = StLoad;
      end
      StLoad: begin
        if (bus.in_valid) begin
          if (dec.goto_wr) begin
            gwe_d   = 1'b1;
            gaddr_d = {rec_st, rec_ch};
            gdata_d = rec_tgt;
            if (gcnt_q != '1) gcnt_d = gcnt_q + 1'b1;
          end
          if (dec.fail_wr) begin
            fwe_d   = 1'b1;
            faddr_d = {{CHARA_W{1'b0}}, rec_st};
            fdata_d = rec_tgt;
            if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
          end
          if (dec.bad)    err_d   = 1'b1;
          if (dec.is_end) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      clr_q   <= '0;
      gwe_q   <= 1'b0;
      gaddr_q <= '0;
      gdata_q <= '0;
      fwe_q   <= 1'b0;
      faddr_q <= '0;
      fdata_q <= '0;
      err_q   <= 1'b0;
      gcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      gwe_q   <= gwe_d;
      gaddr_q <= gaddr_d;
      gdata_q <= gdata_d;
      fwe_q   <= fwe_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      err_q   <= err_d;
      gcnt_q  <= gcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Clear writes come straight from the counter; load writes from the registered stage.
  always_comb begin
    bus.in_ready   = (state_q == StLoad);
    bus.goto_we    = gwe_q;
    bus.goto_waddr = gaddr_q;
    bus.goto_wdata = gdata_q;
    bus.fail_we    = fwe_q;
    bus.fail_waddr = faddr_q;
    bus.fail_wdata = fdata_q;
    if (state_q == StClear) begin
      bus.goto_we    = 1'b1;
      bus.goto_waddr = clr_q;
      bus.goto_wdata = (clr_q[ADDR_W-1:CHARA_W] == '0) ? '0 : FAIL_MARK;
      bus.fail_we    = (clr_q[CHARA_W-1:0] == '0);
      bus.fail_waddr = {{CHARA_W{1'b0}}, clr_q[ADDR_W-1:CHARA_W]};
      bus.fail_wdata = '0;
    end
  end

  assign busy_o     = (state_q == StClear) || (state_q == StLoad);
  assign done_o     = (state_q == StDone);
  assign err_o      = err_q;
  assign goto_cnt_o = gcnt_q;
  assign fail_cnt_o = fcnt_q;

endmodule
